// File: rtl/ps_acq_pkg.sv
// Shared definitions for the proximity-sensor acquisition path:
// data width, reset value of the published word, FSM states and
// the accumulator width helper.
package ps_acq_pkg;

    localparam int PS_W = 18;
    localparam logic [PS_W-1:0] PS_RESET_VAL = 18'h3FFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_UPDATE  = 2'd2,
        S_PUBLISH = 2'd3
    } acq_state_e;

    // Sum of 2^avg_log2 samples of PS_W bits needs avg_log2 extra bits.
    function automatic int acc_width(input int avg_log2);
        return PS_W + avg_log2;
    endfunction

endpackage

// File: rtl/ps_boxcar_filter.sv
// Running boxcar average over the last 2^AVG_LOG2 pushed samples.
// A one-cycle push strobe replaces the oldest sample with the new one
// and updates the running sum. full_o rises once the window has been
// filled for the first time after reset.
module ps_boxcar_filter
    import ps_acq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [PS_W-1:0] data_i,
    output logic [PS_W-1:0] avg_o,
    output logic            full_o
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int ACC_W  = acc_width(AVG_LOG2);
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [PS_W-1:0]   samp_q [N];
    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Next sum, pointer and fill level for a push; the evicted slot is
    // always part of the current sum, so the subtraction never underflows.
    always_comb begin
        acc_d  = acc_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (push_i) begin
            acc_d  = acc_q + ACC_W'(data_i) - ACC_W'(samp_q[wptr_q]);
            wptr_d = (wptr_q == PTR_W'(N - 1)) ? '0 : wptr_q + 1'b1;
            if (fill_q != FILL_W'(N)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Window storage and running state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                samp_q[i] <= '0;
            end
            acc_q  <= '0;
            wptr_q <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            if (push_i) begin
                samp_q[wptr_q] <= data_i;
            end
        end
    end

    assign avg_o  = acc_q[ACC_W-1:AVG_LOG2];
    assign full_o = (fill_q == FILL_W'(N));

endmodule

// File: rtl/ps_data_acq.sv
// Producer of the filtered PS_DATA word: periodically requests a raw
// sample over REQ/ACK, pushes it through a boxcar filter and publishes
// the average with a one-cycle PS_VALID strobe.
// Optional macro PS_ACQ_TIMEOUT_EN: aborts a request after
// TIMEOUT_CYCLES cycles without ACK and raises the sticky ERR flag.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   S_IDLE    | count the sample period while ENABLE is high
//   S_REQ     | REQ high, waiting for ACK (or timeout)
//   S_UPDATE  | push captured sample into the filter
//   S_PUBLISH | publish the average once the window is full
module ps_data_acq
    import ps_acq_pkg::*;
#(
    parameter int SAMPLE_PERIOD  = 1024,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENABLE,
    output logic            REQ,
    input  logic            ACK,
    input  logic [PS_W-1:0] RAW_DATA,
    output logic [PS_W-1:0] PS_DATA,
    output logic            PS_VALID,
    output logic            ERR
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    if (SAMPLE_PERIOD < 2 || AVG_LOG2 < 0 || AVG_LOG2 > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps_data_acq: illegal parameter combination");
    end

    acq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             req_q,   req_d;
    logic [PS_W-1:0]  raw_q;
    logic [PS_W-1:0]  ps_data_q, ps_data_d;
    logic             ps_valid_q, ps_valid_d;
    logic [PS_W-1:0]  avg;
    logic             full;
    logic             push;
    logic             tmo_abort;

`ifdef PS_ACQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    assign push = (state_q == S_UPDATE);

    ps_boxcar_filter #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .push_i (push),
        .data_i (raw_q),
        .avg_o  (avg),
        .full_o (full)
    );

    // Next-state, period counter, request and publish decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_abort = 1'b0;
`ifdef PS_ACQ_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    if (cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_REQ: begin
                if (ACK) begin
                    state_d = S_UPDATE;
                end
`ifdef PS_ACQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_abort = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_UPDATE:  state_d = S_PUBLISH;
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        req_d      = (state_d == S_REQ);
        ps_valid_d = (state_q == S_PUBLISH) && full;
        ps_data_d  = ps_valid_d ? avg : ps_data_q;

`ifdef PS_ACQ_TIMEOUT_EN
        err_d = err_q;
        if (tmo_abort) begin
            err_d = 1'b1;
        end else if (state_q == S_UPDATE) begin
            err_d = 1'b0;
        end
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            raw_q      <= '0;
            ps_data_q  <= PS_RESET_VAL;
            ps_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ps_data_q  <= ps_data_d;
            ps_valid_q <= ps_valid_d;
            if (state_q == S_REQ && ACK) begin
                raw_q <= RAW_DATA;
            end
        end
    end

`ifdef PS_ACQ_TIMEOUT_EN
    // Request timeout counter and sticky error flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign REQ      = req_q;
    assign PS_DATA  = ps_data_q;
    assign PS_VALID = ps_valid_q;

endmodule

// File: tb/tb_ps_data_acq.sv
// Scoreboard bench for ps_data_acq: a sliding-window model predicts each
// published average and the cycle it must appear in; a monitor pops and
// compares on every PS_VALID strobe.
module tb_ps_data_acq;

    localparam int SP  = 16;
    localparam int LG  = 2;
    localparam int TMO = 32;
    localparam int N   = 1 << LG;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        REQ;
    logic        ACK;
    logic [17:0] RAW_DATA;
    logic [17:0] PS_DATA;
    logic        PS_VALID;
    logic        ERR;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [17:0] d;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned win[$];

    ps_data_acq #(
        .SAMPLE_PERIOD  (SP),
        .AVG_LOG2       (LG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .REQ      (REQ),
        .ACK      (ACK),
        .RAW_DATA (RAW_DATA),
        .PS_DATA  (PS_DATA),
        .PS_VALID (PS_VALID),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a new sample enters the window; once N samples are present,
    // the average must appear two edges after the ACK-sampling edge.
    task automatic model_sample(input logic [17:0] v, input int ack_edge);
        longint unsigned sum;
        exp_t e;
        win.push_back(int'(v));
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
            sum = 0;
            foreach (win[i]) sum += longint'(win[i]);
            e.d = 18'(sum / N);
            e.c = ack_edge + 2;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every strobe must match the oldest prediction.
    always @(negedge CLK) begin
        if (PS_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(PS_DATA), 32'h0);
                chk("unexpected_valid_flag", 32'(PS_VALID), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ps_data", 32'(PS_DATA), 32'(e.d));
                chk("valid_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (REQ) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_wait_timeout", 32'(REQ), 32'h1);
    endtask

    task automatic send_ack(input logic [17:0] v);
        ACK      = 1'b1;
        RAW_DATA = v;
        model_sample(v, cyc + 1);
        @(negedge CLK);
        ACK      = 1'b0;
        RAW_DATA = 18'($urandom);
        chk("req_drop_after_ack", 32'(REQ), 32'h0);
    endtask

    task automatic do_sample(input logic [17:0] v, input int dly);
        bit ok;
        wait_req(ok);
        if (ok) begin
            repeat (dly) @(negedge CLK);
            send_ack(v);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [17:0] saved;
        logic [17:0] dir_vals [4];

        RESET    = 1'b1;
        ENABLE   = 1'b0;
        ACK      = 1'b0;
        RAW_DATA = '0;
        settle(3);
        RESET = 1'b0;

        // Idle with ENABLE low: reset values hold, no request.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("rst_ps_data", 32'(PS_DATA), 32'h3FFFF);
            chk("rst_ps_valid", 32'(PS_VALID), 32'h0);
            chk("rst_req", 32'(REQ), 32'h0);
            chk("rst_err", 32'(ERR), 32'h0);
        end

        // Warm-up with four directed samples.
        ENABLE = 1'b1;
        dir_vals = '{18'h100, 18'h200, 18'h300, 18'h400};
        foreach (dir_vals[i]) do_sample(dir_vals[i], 0);
        settle(4);
        chk("first_avg", 32'(PS_DATA), 32'h280);

        do_sample(18'h800, 0);
        settle(4);
        chk("wrap_avg", 32'(PS_DATA), 32'h440);

        for (int i = 0; i < 8; i++) do_sample(18'h3FFFF, 1);
        settle(4);
        chk("max_avg", 32'(PS_DATA), 32'h3FFFF);
        do_sample(18'h00000, 0);
        settle(4);
        chk("max_then_zero", 32'(PS_DATA), 32'h2FFFF);

        // Random samples with random handshake delay.
        for (int i = 0; i < 20; i++) begin
            do_sample(18'($urandom), int'($urandom_range(0, 5)));
        end

`ifdef PS_ACQ_TIMEOUT_EN
        settle(4);
        saved = PS_DATA;
        n = 0;
        wait_req(ok);
        if (ok) begin
            n = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge CLK);
                if (!REQ) break;
                n++;
            end
        end
        chk("tmo_req_cycles", 32'(n), 32'(TMO));
        chk("tmo_err_set", 32'(ERR), 32'h1);
        chk("tmo_data_kept", 32'(PS_DATA), 32'(saved));
        do_sample(18'($urandom), 1);
        @(negedge CLK);
        chk("tmo_err_clear", 32'(ERR), 32'h0);
`endif

        // ENABLE dropped during a request: finishes, then parks.
        wait_req(ok);
        if (ok) begin
            @(negedge CLK);
            ENABLE = 1'b0;
            repeat (4) @(negedge CLK);
            chk("req_held_after_disable", 32'(REQ), 32'h1);
            send_ack(18'($urandom));
        end
        n = 0;
        for (int i = 0; i < 3 * SP + 10; i++) begin
            @(negedge CLK);
            if (REQ) n++;
        end
        chk("no_req_when_disabled", 32'(n), 32'h0);
        chk("queue_after_disable", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a request.
        ENABLE = 1'b1;
        wait_req(ok);
        if (ok) begin
            RESET = 1'b1;
            #1;
            chk("req_async_drop", 32'(REQ), 32'h0);
            win.delete();
            settle(2);
            chk("reset_ps_data", 32'(PS_DATA), 32'h3FFFF);
            RESET = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            do_sample(18'($urandom), int'($urandom_range(0, 3)));
            if (i < N - 1) begin
                settle(3);
                chk("warmup_no_publish", 32'(PS_DATA), 32'h3FFFF);
            end
        end

        // Drain outstanding predictions.
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        chk("drain_queue", 32'(exp_q.size()), 32'h0);
`ifndef PS_ACQ_TIMEOUT_EN
        chk("err_tied_low", 32'(ERR), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
